seq_alu: RTL and testbench

// Parametrised multi-cycle successor to the single-cycle execute ALU. It is

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 153 +++++++++++++++
 tb/tb_seq_alu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Execute-stage ALU handshake bundle: operand request channel and result channel.
// The master drives operands and takes results; the ALU itself is the slave.
interface seq_alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [2:0]      op_ctrl;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_op;
  logic            b_zero;

  modport master (
    output in_valid, rs1, rs2, op_ctrl, out_ready,
    input  in_ready, out_valid, alu_op, b_zero
  );

  modport slave (
    input  in_valid, rs1, rs2, op_ctrl, out_ready,
    output in_ready, out_valid, alu_op, b_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle XLEN-wide ALU: single-cycle ADD/SUB, iterative shift-add MUL/MULHU
// and restoring DIV/REM (unsigned), with valid/ready on both sides.
module seq_alu #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_alu_if.slave    bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_REM   = 3'b100;
  localparam logic [2:0] OP_MULHU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_long_op;
  logic [XLEN-1:0] w_quick;

  logic [2:0]      r_op;
  logic [XLEN-1:0] r_opb;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mq;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_alu_op;
  logic            r_b_zero;

  logic [XLEN-1:0] w_src_acc;
  logic [XLEN-1:0] w_src_mq;
  logic [XLEN-1:0] w_src_opb;
  logic            w_src_mul;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_acc_next;
  logic [XLEN-1:0] w_mq_next;
  logic [XLEN-1:0] w_final;

  assign w_long_op = (bus.op_ctrl == OP_MUL) || (bus.op_ctrl == OP_MULHU) ||
                     (bus.op_ctrl == OP_DIV) || (bus.op_ctrl == OP_REM);
  assign w_accept  = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_in_ready   = 1'b0;
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_next = w_long_op ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (r_cnt == CNT_LAST) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_in_ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) w_state_next = w_long_op ? S_BUSY : S_DONE;
          else              w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_quick = '0;
    case (bus.op_ctrl)
      OP_ADD:  w_quick = bus.rs1 + bus.rs2;
      OP_SUB:  w_quick = bus.rs1 - bus.rs2;
      default: w_quick = '0;
    endcase
  end

  // The first iteration runs on the accept edge straight from the operand bus,
  // so the remaining XLEN-1 iterations land the result XLEN edges after accept.
  assign w_src_acc = w_accept ? '0 : r_acc;
  assign w_src_mq  = w_accept ? bus.rs1 : r_mq;
  assign w_src_opb = w_accept ? bus.rs2 : r_opb;
  assign w_src_mul = w_accept ? ((bus.op_ctrl == OP_MUL) || (bus.op_ctrl == OP_MULHU))
                              : ((r_op == OP_MUL) || (r_op == OP_MULHU));

  assign w_sum   = {1'b0, w_src_acc} + (w_src_mq[0] ? {1'b0, w_src_opb} : '0);
  assign w_trial = {w_src_acc, w_src_mq[XLEN-1]} - {1'b0, w_src_opb};

  // Multiply: {acc,mq} shifts right, product ends up high:low in acc:mq.
  // Divide: dividend shifts out of mq into acc, quotient bits shift into mq.
  always_comb begin
    w_acc_next = w_src_acc;
    w_mq_next  = w_src_mq;
    if (w_src_mul) begin
      w_acc_next = w_sum[XLEN:1];
      w_mq_next  = {w_sum[0], w_src_mq[XLEN-1:1]};
    end else if (!w_trial[XLEN]) begin
      w_acc_next = w_trial[XLEN-1:0];
      w_mq_next  = {w_src_mq[XLEN-2:0], 1'b1};
    end else begin
      w_acc_next = {w_src_acc[XLEN-2:0], w_src_mq[XLEN-1]};
      w_mq_next  = {w_src_mq[XLEN-2:0], 1'b0};
    end
  end

  assign w_final = ((r_op == OP_MUL) || (r_op == OP_DIV)) ? w_mq_next : w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_cnt    <= '0;
      r_alu_op <= '0;
      r_b_zero <= 1'b0;
    end else if (w_accept) begin
      r_op  <= bus.op_ctrl;
      r_opb <= bus.rs2;
      if (w_long_op) begin
        r_acc <= w_acc_next;
        r_mq  <= w_mq_next;
        r_cnt <= CNT_INIT;
      end else begin
        r_alu_op <= w_quick;
        r_b_zero <= (w_quick == '0);
      end
    end else if (r_state == S_BUSY) begin
      r_acc <= w_acc_next;
      r_mq  <= w_mq_next;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_LAST) begin
        r_alu_op <= w_final;
        r_b_zero <= (w_final == '0);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.alu_op    = r_alu_op;
  assign bus.b_zero    = r_b_zero;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus random ops on
// XLEN=32 and XLEN=8 instances, checked against an arithmetic reference model.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic        sel8 = 1'b0;
  logic [31:0] a_drv = '0;
  logic [31:0] b_drv = '0;
  logic [2:0]  op_drv = '0;

  seq_alu_if #(.XLEN(32)) bus32();
  seq_alu_if #(.XLEN(8))  bus8();

  assign bus32.in_valid  = iv & ~sel8;
  assign bus32.rs1       = a_drv;
  assign bus32.rs2       = b_drv;
  assign bus32.op_ctrl   = op_drv;
  assign bus32.out_ready = ordy;
  assign bus8.in_valid   = iv & sel8;
  assign bus8.rs1        = a_drv[7:0];
  assign bus8.rs2        = b_drv[7:0];
  assign bus8.op_ctrl    = op_drv;
  assign bus8.out_ready  = ordy;

  seq_alu #(.XLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  seq_alu #(.XLEN(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  wire        cur_in_ready  = sel8 ? bus8.in_ready  : bus32.in_ready;
  wire        cur_out_valid = sel8 ? bus8.out_valid : bus32.out_valid;
  wire        cur_b_zero    = sel8 ? bus8.b_zero    : bus32.b_zero;
  wire [31:0] cur_alu_op    = sel8 ? {24'b0, bus8.alu_op} : bus32.alu_op;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_long(input logic [2:0] op);
    return (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
  endfunction

  function automatic longint unsigned ref_res(input int w, input logic [2:0] op,
                                              input longint unsigned a, input longint unsigned b);
    longint unsigned m;
    m = (w == 8) ? 64'hFF : 64'hFFFF_FFFF;
    case (op)
      3'd0:    return (a + b) & m;
      3'd1:    return (a - b) & m;
      3'd3:    return (a * b) & m;
      3'd5:    return ((a * b) >> w) & m;
      3'd2:    return (b == 0) ? m : a / b;
      3'd4:    return (b == 0) ? a : a % b;
      default: return 0;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit drain);
    int w;
    int lat;
    int guard;
    longint unsigned exp;
    logic [31:0] am;
    logic [31:0] bm;
    w  = sel8 ? 8 : 32;
    am = sel8 ? {24'b0, a[7:0]} : a;
    bm = sel8 ? {24'b0, b[7:0]} : b;
    exp = ref_res(w, op, am, bm);
    a_drv = am; b_drv = bm; op_drv = op; iv = 1'b1; ordy = 1'b0;
    guard = 0;
    while (!cur_in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    chk("accept_wait", guard < 100, 1'b1);
    @(posedge clk); #1;
    iv = 1'b0; a_drv = $urandom; b_drv = $urandom; op_drv = 3'($urandom);
    lat = 1;
    while (!cur_out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, is_long(op) ? w : 1);
    chk("result", cur_alu_op, exp);
    chk("b_zero", cur_b_zero, exp == 0);
    $display("xlen=%0d op=%0d a=%h b=%h res=%h exp=%h lat=%0d", w, op, am, bm, cur_alu_op, exp, lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_result", cur_alu_op, exp);
      chk("hold_valid", cur_out_valid, 1'b1);
      chk("hold_in_ready", cur_in_ready, 1'b0);
    end
    if (drain) begin
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
      chk("drained", cur_out_valid, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rb;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid32", bus32.out_valid, 1'b0);
    chk("rst_alu32", bus32.alu_op, 32'h0);
    chk("rst_bz32", bus32.b_zero, 1'b0);
    chk("rst_valid8", bus8.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", bus32.in_ready, 1'b1);

    run_op(3'd0, 32'hFFFF_FFFF, 32'h1, 0, 1);
    run_op(3'd1, 32'd5, 32'd7, 0, 1);
    run_op(3'd3, 32'h0001_2345, 32'h0001_0000, 0, 1);
    run_op(3'd5, 32'h0001_2345, 32'h0001_0000, 0, 1);
    run_op(3'd2, 32'd100, 32'd7, 0, 1);
    run_op(3'd4, 32'd100, 32'd7, 0, 1);
    run_op(3'd2, 32'd9, 32'd0, 0, 1);
    run_op(3'd4, 32'd9, 32'd0, 0, 1);
    run_op(3'd6, 32'd9, 32'd4, 0, 1);

    // backpressure, then a same-edge hand-over to the next op
    run_op(3'd1, 32'd10, 32'd3, 5, 0);
    a_drv = 32'd2; b_drv = 32'd3; op_drv = 3'd0; iv = 1'b1; ordy = 1'b1;
    #1;
    chk("handover_in_ready", cur_in_ready, 1'b1);
    @(posedge clk); #1;
    iv = 1'b0; ordy = 1'b0;
    chk("handover_valid", cur_out_valid, 1'b1);
    chk("handover_result", cur_alu_op, 32'd5);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;

    // reset in the middle of a divide
    a_drv = 32'd1000; b_drv = 32'd3; op_drv = 3'd2; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", bus32.out_valid, 1'b0);
    chk("abort_alu", bus32.alu_op, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_result", bus32.out_valid, 1'b0);
    run_op(3'd0, 32'd1, 32'd1, 0, 1);

    for (int i = 0; i < 40; i++) begin
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op(3'($urandom_range(0, 7)), $urandom, rb, $urandom_range(0, 2), 1);
    end

    sel8 = 1'b1;
    run_op(3'd3, 32'hFF, 32'hFF, 0, 1);
    run_op(3'd5, 32'hFF, 32'hFF, 0, 1);
    run_op(3'd7, 32'h12, 32'h34, 0, 1);
    run_op(3'd2, 32'd200, 32'd0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      run_op(3'($urandom_range(0, 7)), $urandom, rb, $urandom_range(0, 1), 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
